// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Bundle between the EXE stage (master) and the RV32M multiply/divide
// sequencer (slave).
//
// Handshake: EXE holds start with funct3/op1/op2 stable while the instruction
// sits in EXE. The sequencer accepts in IDLE when start=1 and flush=0. It
// keeps stall_req high until the result is ready. It then pulses
// result_valid for exactly one cycle, and in that cycle result carries the
// value. flush abandons any operation in flight and produces no pulse.
//
// Signals:
//   start        EXE -> seq  M-extension instruction present in EXE
//   funct3       EXE -> seq  operation select
//   op1, op2     EXE -> seq  rs1 / rs2 values
//   flush        EXE -> seq  pipeline flush, aborts the operation
//   stall_req    seq -> EXE  freeze IF/ID/EXE
//   busy         seq -> EXE  sequencer not idle (registered)
//   result_valid seq -> EXE  one-cycle result strobe
//   result       seq -> EXE  registered result
//   state_dbg    seq -> EXE  current FSM state, for observation only
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            stall_req;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [1:0]      state_dbg;

    modport master (
        output start, funct3, op1, op2, flush,
        input  stall_req, busy, result_valid, result, state_dbg
    );

    modport slave (
        input  start, funct3, op1, op2, flush,
        output stall_req, busy, result_valid, result, state_dbg
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit that sits
// beside EXE. It runs an iterative shift-add multiplier and a restoring
// shift-subtract divider on operand magnitudes, then applies the signs in
// a FIXUP cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   muldiv_sequencer_if.slave (start/funct3/op1/op2/flush in,
//         stall_req/busy/result_valid/result/state_dbg out)
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiply ops use a single-cycle
//                       multiplier on accept and go straight to DONE.
//                       Divide ops always iterate.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nxt;

    logic [CNT_W-1:0] count;
    logic [2:0]       fn;       // latched funct3
    logic             neg_res;  // negate product / quotient in FIXUP
    logic             neg_rem;  // remainder follows dividend sign
    logic [XLEN-1:0]  hi;       // mul: upper product, div: partial remainder
    logic [XLEN-1:0]  lo;       // mul: multiplier/lower product, div: dividend/quotient
    logic [XLEN-1:0]  opnd;     // mul: multiplicand, div: divisor
    logic [XLEN-1:0]  result_q;
    logic             busy_q;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    logic            accept, is_div, s1, s2, neg1, neg2;
    logic            div_zero, div_ovf, special, fast;
    logic [XLEN-1:0] mag1, mag2;

    assign accept = (state == IDLE) && bus.start && !bus.flush;
    assign is_div = bus.funct3[2];
    // op1 is signed for MULH/MULHSU/DIV/REM, op2 for MULH/DIV/REM.
    assign s1 = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign s2 = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                (bus.funct3 == 3'b110);
    assign neg1 = s1 && bus.op1[XLEN-1];
    assign neg2 = s2 && bus.op2[XLEN-1];
    // -INT_MIN wraps back to 0x80000000, which is the correct unsigned magnitude.
    assign mag1 = neg1 ? -bus.op1 : bus.op1;
    assign mag2 = neg2 ? -bus.op2 : bus.op2;

    assign div_zero = is_div && (bus.op2 == '0);
    // Only signed DIV/REM (funct3[0]=0) can overflow.
    assign div_ovf  = is_div && !bus.funct3[0] &&
                      (bus.op1 == INT_MIN) && (bus.op2 == '1);
    assign special  = div_zero || div_ovf;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
    assign fast   = !is_div;
    assign fast_a = {{XLEN{neg1}}, bus.op1};
    assign fast_b = {{XLEN{neg2}}, bus.op2};
    assign fast_p = fast_a * fast_b;
`else
    assign fast = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath (all sums XLEN+1 bits)
    // ------------------------------------------------------------------
    logic [XLEN:0] add_sum, rsh, sub;
    logic          ge;

    assign add_sum = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
    assign rsh     = {hi, lo[XLEN-1]};
    assign ge      = (rsh >= {1'b0, opnd});
    assign sub     = rsh - {1'b0, opnd};

    // ------------------------------------------------------------------
    // Sign fixup and result select
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_res;

    assign prod_s = neg_res ? -{hi, lo} : {hi, lo};
    assign quot_s = neg_res ? -lo : lo;
    assign rem_s  = neg_rem ? -hi : hi;

    always_comb begin
        fix_res = prod_s[XLEN-1:0];
        case (fn)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quot_s;
            default:                fix_res = rem_s;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (special || fast) ? DONE : CALC;
            CALC:    if (count == LAST_CNT) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;  // start seen here is the same instruction
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    // FSM: outputs
    always_comb begin
        bus.stall_req    = accept || (state == CALC) || (state == FIXUP);
        bus.result_valid = (state == DONE) && !bus.flush;
        bus.state_dbg    = state;
    end

    assign bus.busy   = busy_q;
    assign bus.result = result_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            count    <= '0;
            fn       <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            result_q <= '0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        fn      <= bus.funct3;
                        count   <= '0;
                        hi      <= '0;
                        neg_res <= neg1 ^ neg2;
                        neg_rem <= neg1;
                        if (is_div) begin
                            lo   <= mag1;
                            opnd <= mag2;
                        end else begin
                            lo   <= mag2;
                            opnd <= mag1;
                        end
                        if (div_zero)
                            result_q <= bus.funct3[1] ? bus.op1 : '1;
                        else if (div_ovf)
                            result_q <= bus.funct3[1] ? '0 : INT_MIN;
`ifdef MULDIV_FAST_MUL_EN
                        else if (fast)
                            result_q <= (bus.funct3 == 3'b000) ?
                                        fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif
                    end
                end
                CALC: begin
                    count <= count + CNT_W'(1);
                    if (!fn[2]) begin
                        {hi, lo} <= {add_sum, lo[XLEN-1:1]};
                    end else begin
                        hi <= ge ? sub[XLEN-1:0] : rsh[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], ge};
                    end
                end
                FIXUP: begin
                    if (!bus.flush) result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, placed beside the EXE stage.
- EXE raises start when opcode 0110011 / funct7 0000001 is decoded.
- The block holds the pipeline through stall_req while its shift-add / shift-subtract engine iterates.
- It returns a registered 32-bit result that EXE muxes into mem_alu_result.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, width of iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  M-extension instruction present in EXE
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  input  XLEN  rs1 value (reg1_data)
- op2  input  XLEN  rs2 value (reg2_data)
- flush  input  1  pipeline flush (taken jump/branch), aborts operation
- stall_req  output  1  freeze IF/ID/EXE; combinational from state and start
- busy  output  1  state is not IDLE; registered
- result_valid  output  1  one-cycle pulse, result valid
- result  output  XLEN  registered result; holds until next accept

Behaviour:
- Reset: state=IDLE; count=0; result=0; result_valid=0; busy=0; internal acc/quotient/remainder/operand registers=0. Reset mid-operation aborts immediately with no result.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1, flush=0: accept.
  - Latch funct3.
  - Compute sign flags: op1 is signed for MULH/MULHSU/DIV/REM; op2 is signed for MULH/DIV/REM.
  - Latch magnitudes and set count=0.
  - Divide by zero (op2==0, funct3[2]=1): go straight to DONE with DIV/DIVU=32'hFFFFFFFF and REM/REMU=op1.
  - Signed overflow (DIV/REM, op1=32'h80000000, op2=32'hFFFFFFFF): go straight to DONE with DIV=32'h80000000 and REM=0.
  - Otherwise go to CALC.
- CALC: one iteration per cycle.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring shift-subtract; each step yields one quotient bit, MSB first.
  - count increments; leave after XLEN iterations (count==XLEN-1) to FIXUP.
- FIXUP:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Select low word (MUL), high word (MULH*), quotient, or remainder into result.
  - Go to DONE.
- DONE: result_valid=1, stall_req=0, go to IDLE. A start asserted in DONE is ignored, because it is the same instruction leaving EXE.
- Latency:
  - Normal operation: accept in cycle 0, CALC in cycles 1..32, FIXUP in cycle 33, result_valid in cycle 34.
  - Special case: result_valid in cycle 1.
- stall_req = (IDLE & start & ~flush) | CALC | FIXUP.
- flush in any state: next state IDLE, no result_valid, result unchanged. flush has priority over start.
- Arithmetic:
  - All intermediate sums are XLEN+1 bits wide; no overflow is lost.
  - Negation is two's complement.
  - |0x80000000| handled as unsigned 0x80000000.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - Multiply ops (funct3[2]=0) skip CALC/FIXUP.
  - The 64-bit signed/unsigned product is computed with a single-cycle multiplier on accept and registered; state goes to DONE.
  - result_valid in cycle 1. Divide ops are unchanged.
- Undefined: all ops use the iterative path; no hardware multiplier is inferred.

Test Plan:
- MUL op1=7, op2=-3 (0xFFFFFFFD) -> stall_req high cycles 0..33, result_valid in cycle 34 (cycle 1 with MULDIV_FAST_MUL_EN), result=0xFFFFFFEB.
- MULHU op1=op2=0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU op1=-1, op2=2 -> result=0xFFFFFFFF.
- DIV op1=-7, op2=2 -> result=0xFFFFFFFD. REM with same operands -> result=0xFFFFFFFF. DIVU op1=100, op2=7 -> result=14.
- DIV op2=0, op1=5 -> result=0xFFFFFFFF in cycle 1. REM op1=0x80000000, op2=-1 -> result=0 in cycle 1.
- Start DIVU, assert flush in cycle 10 -> IDLE in cycle 11, stall_req=0, no result_valid, result keeps prior value. A back-to-back start in cycle 11 is accepted.
- Assert rst asynchronously in cycle 20 of a MUL -> busy, result_valid and result are 0 immediately. Start held high through DONE -> exactly one result_valid pulse.
